vector_sum_serializer: RTL and testbench
========================================

Name: vector_sum_serializer

Overview:
- Downstream stage of the 11-element vector-add AXI-Stream wrapper.
- Consumes its 121-bit packed sum vector (S0..S10, each 11 bits, S0 in MSBs).
- Emits the vector as N_ELEM scalar AXI-Stream beats, S0 first, with a last flag on the final element.
- Feeds scalar consumers: UART/DMA packers and scalar accumulators.

Parameters:
- N_ELEM, 11, number of elements per vector.
- ELEM_W, 11, bits per element.
- IN_W, 121, packed input width; must equal N_ELEM*ELEM_W.
- IDX_W, 4, index counter width; ceil(log2(N_ELEM)).

Ports:
- aclk  input  1  clock; all logic on the rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- enable  input  1  global advance enable; 0 freezes all state.
- s_axi_data  input  IN_W  packed vector; element k at bits [IN_W-1-k*ELEM_W -: ELEM_W].
- s_axi_valid  input  1  upstream vector valid.
- s_axi_ready  output  1  vector accepted when valid&ready&enable.
- m_axi_data  output  ELEM_W  current element, registered.
- m_axi_valid  output  1  element valid.
- m_axi_last  output  1  high with the element of index N_ELEM-1.
- m_axi_ready  input  1  downstream ready.

Behaviour:
- Reset: aresetn=0 asynchronously forces the following. Any partial vector is dropped, with no further beats after reset release.
  - state=IDLE, idx=0, shift register=0, holding buffer empty.
  - m_axi_data=0, m_axi_valid=0, m_axi_last=0, s_axi_ready=1.
- enable=0:
  - No register changes.
  - Handshakes that occur are ignored, and the bench must not count them.
  - m_axi_valid and m_axi_data stay stable, so AXI stability holds.
- States:
  - IDLE: s_axi_ready=1. On s_axi_valid&s_axi_ready&enable:
    - Capture s_axi_data into the shift register, set s_axi_ready<=0, idx<=0.
    - Register m_axi_data<=element 0, m_axi_valid<=1, m_axi_last<=(N_ELEM==1).
    - Go to SEND.
  - SEND: hold the beat until m_axi_valid&m_axi_ready&enable.
    - If idx<N_ELEM-1: idx++, present the next element, and set m_axi_last=(idx+1==N_ELEM-1).
    - If idx==N_ELEM-1: m_axi_valid<=0, m_axi_last<=0, s_axi_ready<=1, go to IDLE.
- Latency and throughput:
  - Accept in cycle k gives the first beat valid in cycle k+1.
  - With m_axi_ready held high, beats occur in cycles k+1..k+N_ELEM.
  - s_axi_ready rises in cycle k+N_ELEM+1, giving a period of N_ELEM+1 cycles per vector.
- Element extraction: shift the register left by ELEM_W per beat, or index by idx; either gives identical output order.
- Data is passed unmodified. There is no sign or width change; the 11-bit sum is forwarded raw.
- s_axi_ready never asserts while the last beat is pending without a handshake.
- Simultaneous last-beat handshake and new s_axi_valid: without the optional feature, the new vector is not accepted until the next cycle.

Optional Feature:
- Macro: VSER_PINGPONG_EN.
- Enabled:
  - Adds a one-vector holding buffer; s_axi_ready = !hold_full.
  - A vector can be accepted during SEND.
  - On the last-beat handshake with hold_full: load the holding buffer into the shift register in the same cycle. m_axi_valid stays 1, m_axi_data becomes element 0, hold_full clears, and s_axi_ready rises next cycle.
  - On a simultaneous accept and last-beat handshake with hold empty: the incoming vector loads directly into the shift register.
  - Sustained period: N_ELEM cycles per vector with no bubble.
- Disabled: behaviour exactly as above; the holding buffer is not synthesized.

Decomposition:
- Package vector_stream_pkg holds:
  - N_ELEM/ELEM_W defaults.
  - State enum {IDLE, SEND}.
  - The element-slice helper function, shared with the future upstream vector packer.
- Sub-module vser_hold_buf: the holding register plus full flag, instantiated only under VSER_PINGPONG_EN.
- Everything else lives in one module.

Test Plan:
- Reset, single vector S0..S10=0x001..0x00B with m_axi_ready=1 -> 11 beats 0x001..0x00B in consecutive cycles, last only on 0x00B, s_axi_ready high in the cycle after the last beat.
- Backpressure: m_axi_ready toggles 1,0,0,1 repeating on vector 0x7FF,0x400,... -> data and last stable while stalled; each element emitted exactly once, in order.
- enable=0 for 5 cycles mid-vector (after beat 3) while m_axi_ready=1 -> no beats and no idx change; resumes at beat 4.
- aresetn pulled low during beat 6 of a vector -> outputs go to reset values immediately; after release, the next vector 0x0AA.. starts cleanly at element 0.
- Back-to-back vectors, s_axi_valid always high, m_axi_ready=1:
  - Without macro: 12-cycle period with one idle cycle.
  - With VSER_PINGPONG_EN: 11-cycle period, m_axi_valid continuously high, last every 11th beat.

Source files
------------

// File: rtl/vector_stream_pkg.sv
// Shared types and helpers for the vector-add stream path (packer and serializer).
// Element 0 occupies the most-significant slice of a packed vector.
package vector_stream_pkg;

  localparam int unsigned VS_N_ELEM = 32'd11;
  localparam int unsigned VS_ELEM_W = 32'd11;
  localparam int unsigned VS_IN_W   = VS_N_ELEM * VS_ELEM_W;
  localparam int unsigned VS_IDX_W  = 32'd4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } vser_state_e;

  // Returns element k of a packed vector; out-of-range k yields zero.
  function automatic logic [VS_ELEM_W-1:0] elem_slice(input logic [VS_IN_W-1:0]  vec,
                                                       input logic [VS_IDX_W-1:0] k);
    logic [VS_IN_W-1:0] sh;
    sh = vec >> ((VS_N_ELEM - 32'd1 - 32'(k)) * VS_ELEM_W);
    return sh[VS_ELEM_W-1:0];
  endfunction

endpackage

// File: rtl/vser_hold_buf.sv
// One-vector holding register with a full flag; lets the serializer accept
// the next vector while the current one is still being emitted.
module vser_hold_buf
  import vector_stream_pkg::*;
#(
  parameter int unsigned IN_W = VS_IN_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [IN_W-1:0] data_i,
  output logic [IN_W-1:0] data_o,
  output logic            full_o
);

  logic [IN_W-1:0] data_q;
  logic            full_q;

  // Load wins over clear; the owner never asserts both together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      full_q <= 1'b1;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_q;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/vector_sum_serializer.sv
// Serializes a packed N_ELEM-element sum vector into scalar AXI-Stream beats, S0 first.
// Optional VSER_PINGPONG_EN adds a holding buffer for gap-free back-to-back vectors.
module vector_sum_serializer
  import vector_stream_pkg::*;
#(
  parameter int unsigned N_ELEM = VS_N_ELEM,
  parameter int unsigned ELEM_W = VS_ELEM_W,
  parameter int unsigned IN_W   = VS_IN_W,
  parameter int unsigned IDX_W  = VS_IDX_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [IN_W-1:0]   s_axi_data,
  input  logic              s_axi_valid,
  output logic              s_axi_ready,
  output logic [ELEM_W-1:0] m_axi_data,
  output logic              m_axi_valid,
  output logic              m_axi_last,
  input  logic              m_axi_ready
);

  vser_state_e       state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IN_W-1:0]   shreg_q;
  logic [ELEM_W-1:0] m_data_q;
  logic              m_valid_q;
  logic              m_last_q;

  logic              s_ready_s;
  logic              acc_s;
  logic              beat_s;
  logic              last_beat_s;
  logic              load_s;
  logic [IN_W-1:0]   load_vec_s;
  logic [IDX_W-1:0]  idx_inc_s;

  assign idx_inc_s   = idx_q + IDX_W'(1);
  assign acc_s       = s_axi_valid & s_ready_s & enable;
  assign beat_s      = m_valid_q & m_axi_ready & enable;
  assign last_beat_s = beat_s & (idx_q == IDX_W'(N_ELEM - 32'd1));

`ifdef VSER_PINGPONG_EN
  logic            hold_full_s;
  logic [IN_W-1:0] hold_data_s;
  logic            hold_load_s;
  logic            hold_clear_s;

  assign s_ready_s    = ~hold_full_s;
  // Mid-vector accepts park in the buffer; on the last beat they bypass it.
  assign hold_load_s  = acc_s & (state_q == SEND) & ~last_beat_s;
  assign hold_clear_s = last_beat_s & hold_full_s;

  vser_hold_buf #(
    .IN_W (IN_W)
  ) u_hold_buf (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .load_i  (hold_load_s),
    .clear_i (hold_clear_s),
    .data_i  (s_axi_data),
    .data_o  (hold_data_s),
    .full_o  (hold_full_s)
  );

  // Selects when and from where the shift register is (re)loaded.
  always_comb begin
    load_s     = 1'b0;
    load_vec_s = s_axi_data;
    case (state_q)
      IDLE: load_s = acc_s;
      SEND: begin
        if (last_beat_s && hold_full_s) begin
          load_s     = 1'b1;
          load_vec_s = hold_data_s;
        end else if (last_beat_s && acc_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      default: load_s = 1'b0;
    endcase
  end
`else
  logic s_ready_q;

  assign s_ready_s = s_ready_q;

  // Without a buffer, new vectors are only taken from IDLE.
  always_comb begin
    load_s     = 1'b0;
    load_vec_s = s_axi_data;
    case (state_q)
      IDLE:    load_s = acc_s;
      SEND:    load_s = 1'b0;
      default: load_s = 1'b0;
    endcase
  end

  // Upstream ready drops on accept and returns the cycle after the last beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_ready_q <= 1'b1;
    end else if (load_s) begin
      s_ready_q <= 1'b0;
    end else if (last_beat_s) begin
      s_ready_q <= 1'b1;
    end else begin
      s_ready_q <= s_ready_q;
    end
  end
`endif

  // Main FSM; every update is qualified by enable through load_s/beat_s.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shreg_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (load_s) begin
      state_q   <= SEND;
      idx_q     <= '0;
      shreg_q   <= load_vec_s;
      m_data_q  <= elem_slice(load_vec_s, IDX_W'(0));
      m_valid_q <= 1'b1;
      m_last_q  <= (N_ELEM == 32'd1);
    end else begin
      case (state_q)
        IDLE: state_q <= IDLE;
        SEND: begin
          if (last_beat_s) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
          end else if (beat_s) begin
            idx_q    <= idx_inc_s;
            m_data_q <= elem_slice(shreg_q, idx_inc_s);
            m_last_q <= (idx_inc_s == IDX_W'(N_ELEM - 32'd1));
          end else begin
            state_q <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axi_ready = s_ready_s;
  assign m_axi_data  = m_data_q;
  assign m_axi_valid = m_valid_q;
  assign m_axi_last  = m_last_q;

endmodule

// File: tb/tb_vector_sum_serializer.sv
// Self-checking bench for vector_sum_serializer: a queue of expected beats is
// filled on each accepted vector and drained on each downstream handshake.
module tb_vector_sum_serializer;
  import vector_stream_pkg::*;

  localparam int N  = 11;
  localparam int W  = 11;
  localparam int IW = N * W;
`ifdef VSER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic [IW-1:0] s_axi_data = '0;
  logic          s_axi_valid = 1'b0;
  logic          s_axi_ready;
  logic [W-1:0]  m_axi_data;
  logic          m_axi_valid;
  logic          m_axi_last;
  logic          m_axi_ready = 1'b0;

  vector_sum_serializer dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .enable      (enable),
    .s_axi_data  (s_axi_data),
    .s_axi_valid (s_axi_valid),
    .s_axi_ready (s_axi_ready),
    .m_axi_data  (m_axi_data),
    .m_axi_valid (m_axi_valid),
    .m_axi_last  (m_axi_last),
    .m_axi_ready (m_axi_ready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t exp_q[$];
  int    acc_cyc[$];
  int    last_cyc[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    beats = 0;
  bit    acc_now = 1'b0;
  bit    drop_on_acc = 1'b0;
  bit    b2b = 1'b0;
  bit    bp_mode = 1'b0;
  int    bp_ph = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] seq_vec(input logic [W-1:0] base, input logic [W-1:0] step);
    logic [IW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[IW-1-k*W -: W] = base + W'(k) * step;
    return v;
  endfunction

  function automatic logic [IW-1:0] rand_vec();
    logic [IW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[IW-1-k*W -: W] = W'($urandom);
    return v;
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  // Reference model: outputs checked mid-cycle, then handshakes due at the next edge applied.
  always @(negedge aclk) begin
    acc_now = 1'b0;
    if (!aresetn) begin
      exp_q.delete();
    end else begin
      chk("m_valid", m_axi_valid, exp_q.size() > 0);
      chk("s_ready", s_axi_ready, PP ? (exp_q.size() <= N) : (exp_q.size() == 0));
      if (exp_q.size() > 0) begin
        chk("m_data", m_axi_data, exp_q[0].d);
        chk("m_last", m_axi_last, exp_q[0].l);
      end
      if (enable && m_axi_valid && m_axi_ready && exp_q.size() > 0) begin
        if (exp_q[0].l) last_cyc.push_back(cyc);
        void'(exp_q.pop_front());
        beats++;
      end
      if (enable && s_axi_valid && s_axi_ready) begin
        for (int k = 0; k < N; k++) begin
          beat_t b;
          b.d = s_axi_data[IW-1-k*W -: W];
          b.l = (k == N - 1);
          exp_q.push_back(b);
        end
        acc_cyc.push_back(cyc);
        acc_now = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (acc_now && drop_on_acc) s_axi_valid = 1'b0;
    if (acc_now && b2b) s_axi_data = rand_vec();
    if (bp_mode) begin
      m_axi_ready = (bp_ph % 4 == 0) || (bp_ph % 4 == 3);
      bp_ph++;
    end
  endtask

  task automatic send_vec(input logic [IW-1:0] v);
    int budget;
    s_axi_data  = v;
    s_axi_valid = 1'b1;
    drop_on_acc = 1'b1;
    budget = 50;
    while (s_axi_valid && budget > 0) begin
      tick();
      budget--;
    end
    chk("accept_timeout", s_axi_valid, 1'b0);
    drop_on_acc = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int budget;
    budget = 200;
    while (beats < target && budget > 0) begin
      tick();
      budget--;
    end
    chk("beat_timeout", beats >= target, 1'b1);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 200;
    while ((exp_q.size() > 0 || m_axi_valid) && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int a0;
    int budget;
    logic [IW-1:0] v;
    logic [W-1:0] frz_d;

    // Reset values while held in reset
    tick();
    tick();
    chk("rst_m_data", m_axi_data, 0);
    chk("rst_m_valid", m_axi_valid, 0);
    chk("rst_m_last", m_axi_last, 0);
    chk("rst_s_ready", s_axi_ready, 1);
    aresetn = 1'b1;
    enable = 1'b1;
    m_axi_ready = 1'b1;
    tick();

    // Single vector 0x001..0x00B, streaming without stalls
    b0 = beats;
    send_vec(seq_vec(11'h001, 11'h001));
    wait_idle();
    chk("seq_beats", beats - b0, N);
    chk("seq_latency", last_cyc[$] - acc_cyc[$], N);
    chk("seq_ready_after", s_axi_ready, 1);

    // Backpressure pattern 1,0,0,1 on a vector led by 0x7FF,0x400
    v = rand_vec();
    v[IW-1 -: W] = 11'h7FF;
    v[IW-1-W -: W] = 11'h400;
    b0 = beats;
    bp_mode = 1'b1;
    bp_ph = 0;
    send_vec(v);
    wait_idle();
    bp_mode = 1'b0;
    m_axi_ready = 1'b1;
    chk("bp_beats", beats - b0, N);

    // Freeze with enable=0 after beat 3; an offered vector must be ignored
    b0 = beats;
    v = rand_vec();
    send_vec(v);
    wait_beats(b0 + 3);
    enable = 1'b0;
    s_axi_data = rand_vec();
    s_axi_valid = 1'b1;
    frz_d = v[IW-1-3*W -: W];
    for (int i = 0; i < 5; i++) tick();
    chk("frz_beats", beats - b0, 3);
    chk("frz_valid", m_axi_valid, 1);
    chk("frz_data", m_axi_data, frz_d);
    s_axi_valid = 1'b0;
    enable = 1'b1;
    wait_idle();
    chk("frz_total", beats - b0, N);

    // Asynchronous reset during beat 6, then a clean restart
    b0 = beats;
    send_vec(rand_vec());
    wait_beats(b0 + 6);
    aresetn = 1'b0;
    #1;
    chk("arst_m_data", m_axi_data, 0);
    chk("arst_m_valid", m_axi_valid, 0);
    chk("arst_m_last", m_axi_last, 0);
    chk("arst_s_ready", s_axi_ready, 1);
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    chk("arst_no_beats", m_axi_valid, 0);
    b0 = beats;
    send_vec(seq_vec(11'h0AA, 11'h001));
    wait_idle();
    chk("arst_restart", beats - b0, N);

    // Back-to-back vectors with s_axi_valid held high
    a0 = acc_cyc.size();
    b0 = last_cyc.size();
    s_axi_data = rand_vec();
    s_axi_valid = 1'b1;
    b2b = 1'b1;
    budget = 100;
    while (acc_cyc.size() < a0 + 4 && budget > 0) begin
      tick();
      budget--;
    end
    s_axi_valid = 1'b0;
    b2b = 1'b0;
    chk("b2b_accepts", acc_cyc.size() - a0, 4);
    wait_idle();
    chk("b2b_lasts", last_cyc.size() - b0, 4);
    if (last_cyc.size() >= b0 + 4) begin
      for (int i = 1; i < 4; i++)
        chk("b2b_period", last_cyc[b0+i] - last_cyc[b0+i-1], PP ? N : N + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
